qam_mapper_stream: RTL and testbench
====================================

# qam_mapper_stream

Streaming, parametrised constellation mapper for the OFDM transmit path, sitting between the interleaver and the IFFT subcarrier loader. It accepts one coded-bit group per beat over a valid/ready handshake with a per-beat modulation select, and maps it to a scaled Gray-coded I/Q point. It covers BPSK, QPSK, 16-QAM, 64-QAM and 256-QAM, and flags illegal modes. A two-stage pipeline with backpressure feeds a data-subcarrier index counter that tracks position within an OFDM symbol.

## Interface
Parameters:
- IQ_WIDTH, 16: signed width of each of I and Q.
- MAX_BPSC, 8: maximum bits per subcarrier; 6 disables 256-QAM (N_BPSC=8 then counts as illegal).
- N_SC, 48: data subcarriers per OFDM symbol (index wrap point).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  mapper can accept a beat
- in_bits  in  MAX_BPSC  coded bits; bit 0 is first transmitted
- in_n_bpsc  in  4  bits per subcarrier: 1, 2, 4, 6, 8
- in_last  in  1  last beat of packet
- out_valid  out  1  output point valid
- out_ready  in  1  downstream accepts point
- out_iq  out  2*IQ_WIDTH  {I, Q}, I in the upper half, two's complement
- out_last  out  1  last point of packet
- out_sc_idx  out  6  data-subcarrier index of out_iq, 0..N_SC-1
- mode_err  out  1  sticky: an illegal in_n_bpsc was accepted

## Operation
- Axis split, m = N_BPSC/2:
  - I uses in_bits[m-1:0] and Q uses in_bits[2m-1:m]; within each axis, the lowest index is the Gray MSB.
  - Level L = 2*gray2bin(word) - (2^m - 1).
  - Example for 16-QAM I, (b0,b1) → L: 00→-3, 01→-1, 11→+1, 10→+3.
- BPSK: I = bit0 ? +K1 : -K1, Q = 0.
- Output: I = L_I*K_mod and Q = L_Q*K_mod, exact signed products truncated to IQ_WIDTH (no overflow by construction).
- K_mod = round(2^(IQ_WIDTH-2)/sqrt(Es)) with Es = 1, 2, 10, 42, 170. For IQ_WIDTH=16: K1=16384, K2=11585, K4=5181, K6=2528, K8=1257.
- Unused high in_bits are ignored.
- Illegal in_n_bpsc (0, 3, 5, 7, ≥9, or 8 with MAX_BPSC<8):
  - the beat is still consumed and produces out_iq = 0 with the correct index and last flag;
  - mode_err is set and held until reset.
- Subcarrier index:
  - out_sc_idx increments by 1 per output handshake and wraps N_SC-1→0.
  - After a handshake with out_last=1, the next point has index 0 regardless of the current count.

## Timing
- Reset, sampled on clk while rstn=0: out_valid=0, out_iq=0, out_last=0, out_sc_idx=0, mode_err=0, both pipeline stages empty. in_ready=0 while rstn=0.
- Stage 1 registers the Gray-decoded levels, mode and last flag. Stage 2 registers the product, mode and last flag, and drives the outputs.
- Latency: an input accepted at edge n is presented at edge n+2 when there is no backpressure.
- in_ready = !s1_valid || !s2_valid || out_ready. This combinational path from out_ready is permitted. Throughput is 1 beat per cycle under continuous out_ready.
- A stage advances when its successor is empty or advancing. While out_valid=1 and out_ready=0, out_iq, out_last and out_sc_idx hold stable.
- Input and output handshakes in the same cycle are both honoured.
- Mode changes between consecutive beats take effect per beat, with no bubble.
- Reset mid-packet discards both stages, and the index restarts at 0.

## Structure
- Shared package/header `modulation_pkg` holds the N_BPSC encodings, the Es table, the K_mod constant function of IQ_WIDTH, and the mode-legal check.
- Sub-module `gray_level_decode`: combinational, parametrised on max m. It takes an axis word and m and returns the signed level. It is instantiated twice (I and Q).

## Test plan
- BPSK: in_bits=0, then 1, out_ready=1 → out_iq=0xC0000000, then 0x40000000, two cycles after each accept.
- 16-QAM sweep of all 16 codes → e.g. 4'b0010→{0xEBC3,0xC349} and 4'b0101→{0x3CB7,0x3CB7}. 64-QAM 6'b001001→{0x4520,0x4520}.
- 256-QAM with in_bits=8'hFF → L=+5 per axis (Gray 1111→bin 1010=10, 2*10-15), giving {0x188D,0x188D}. With MAX_BPSC=6, the same beat gives 0 and mode_err=1.
- Backpressure: 100 random beats with out_ready toggling randomly → output sequence equals the golden model, with no drop or duplicate and stable outputs while stalled.
- Index: 60 beats with in_last on beat 52 → out_sc_idx 0..47, 0..4 on the pulse beat, then 0 on beat 53. out_last is aligned to beat 52.
- Reset asserted with two points in flight → out_valid=0 the next cycle, and a new packet starts at index 0.

Source files
------------

// File: rtl/modulation_pkg.sv
// Shared constellation definitions: N_BPSC encodings, symbol energy table,
// per-mode scale constant and the mode-legality check.
package modulation_pkg;

    localparam logic [3:0] N_BPSC_BPSK   = 4'd1;
    localparam logic [3:0] N_BPSC_QPSK   = 4'd2;
    localparam logic [3:0] N_BPSC_QAM16  = 4'd4;
    localparam logic [3:0] N_BPSC_QAM64  = 4'd6;
    localparam logic [3:0] N_BPSC_QAM256 = 4'd8;

    // Average symbol energy of the unscaled odd-integer constellation.
    function automatic int es_of(logic [3:0] n_bpsc);
        case (n_bpsc)
            N_BPSC_BPSK:   return 1;
            N_BPSC_QPSK:   return 2;
            N_BPSC_QAM16:  return 10;
            N_BPSC_QAM64:  return 42;
            N_BPSC_QAM256: return 170;
            default:       return 0;
        endcase
    endfunction

    // round(2^(iq_width-2)/sqrt(Es)) without reals: the largest k with
    // (k-0.5)^2 <= A^2/Es, i.e. (2k-1)^2*Es <= 4*A^2, by binary search.
    function automatic int k_mod(int iq_width, logic [3:0] n_bpsc);
        longint a;
        longint es;
        longint lo;
        longint hi;
        longint mid;
        a  = longint'(1) << (iq_width - 2);
        es = longint'(es_of(n_bpsc));
        if (es == 0) return 0;
        lo = 1;
        hi = a;
        for (int it = 0; it < 64; it++) begin
            if (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if ((2 * mid - 1) * (2 * mid - 1) * es <= 4 * a * a) lo = mid;
                else hi = mid - 1;
            end
        end
        return int'(lo);
    endfunction

    // 256-QAM is only legal when the bit bus is wide enough to carry it.
    function automatic logic mode_legal(logic [3:0] n_bpsc, int max_bpsc);
        case (n_bpsc)
            N_BPSC_BPSK, N_BPSC_QPSK, N_BPSC_QAM16, N_BPSC_QAM64: return 1'b1;
            N_BPSC_QAM256: return (max_bpsc >= 8);
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/qam_mapper_stream_if.sv
// Input bit-group stream and output I/Q point stream of the mapper.
interface qam_mapper_stream_if #(
    parameter int IQ_WIDTH = 16,
    parameter int MAX_BPSC = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [MAX_BPSC-1:0]     in_bits;
    logic [3:0]              in_n_bpsc;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*IQ_WIDTH-1:0]   out_iq;
    logic                    out_last;
    logic [5:0]              out_sc_idx;
    logic                    mode_err;

    modport slave (
        input  in_valid, in_bits, in_n_bpsc, in_last, out_ready,
        output in_ready, out_valid, out_iq, out_last, out_sc_idx, mode_err
    );

    modport master (
        output in_valid, in_bits, in_n_bpsc, in_last, out_ready,
        input  in_ready, out_valid, out_iq, out_last, out_sc_idx, mode_err
    );
endinterface

// File: rtl/gray_level_decode.sv
// Gray-coded axis word to signed odd-integer level. word[0] is the Gray MSB;
// only the low m bits take part.
module gray_level_decode #(
    parameter int MAX_M = 4,
    parameter int LW    = MAX_M + 2
) (
    input  logic [MAX_M-1:0]    word,
    input  logic [3:0]          m,
    output logic signed [LW-1:0] level
);
    logic             bin_bit;
    logic [MAX_M-1:0] val;

    // MSB-first Gray-to-binary, then L = 2*val - (2^m - 1).
    always_comb begin
        bin_bit = 1'b0;
        val     = '0;
        for (int j = 0; j < MAX_M; j++) begin
            if (j < int'(m)) begin
                bin_bit = bin_bit ^ word[j];
                val     = {val[MAX_M-2:0], bin_bit};
            end
        end
        level = LW'(2 * int'(val) - ((1 << int'(m)) - 1));
    end
endmodule

// File: rtl/qam_mapper_stream.sv
// Streaming Gray-coded QAM mapper: stage 1 decodes levels, stage 2 scales
// and drives the outputs; the output handshake steps the subcarrier index.
module qam_mapper_stream
    import modulation_pkg::*;
#(
    parameter int IQ_WIDTH = 16,
    parameter int MAX_BPSC = 8,
    parameter int N_SC     = 48
) (
    input logic                 clk,
    input logic                 rstn,
    qam_mapper_stream_if.slave  bus
);
    localparam int MAX_M = MAX_BPSC / 2;
    localparam int LW    = MAX_M + 2;
    localparam int K1    = k_mod(IQ_WIDTH, N_BPSC_BPSK);
    localparam int K2    = k_mod(IQ_WIDTH, N_BPSC_QPSK);
    localparam int K4    = k_mod(IQ_WIDTH, N_BPSC_QAM16);
    localparam int K6    = k_mod(IQ_WIDTH, N_BPSC_QAM64);
    localparam int K8    = k_mod(IQ_WIDTH, N_BPSC_QAM256);

    logic                  legal;
    logic [3:0]            m_axis;
    logic [MAX_M-1:0]      word_i;
    logic [MAX_M-1:0]      word_q;
    logic signed [LW-1:0]  lvl_i;
    logic signed [LW-1:0]  lvl_q;

    logic                  s1_valid;
    logic signed [LW-1:0]  s1_lvl_i;
    logic signed [LW-1:0]  s1_lvl_q;
    logic [3:0]            s1_mode;
    logic                  s1_last;

    logic                  s2_valid;
    logic [2*IQ_WIDTH-1:0] s2_iq;
    logic                  s2_last;
    logic [5:0]            sc_idx;
    logic                  mode_err;

    logic                  s1_adv;
    logic                  s2_adv;
    logic                  in_fire;
    logic                  out_fire;
    int                    k_sel;
    int                    prod_i;
    int                    prod_q;

    // Axis split: BPSK uses bit 0 alone on I; otherwise m = N_BPSC/2 per axis.
    always_comb begin
        legal  = mode_legal(bus.in_n_bpsc, MAX_BPSC);
        m_axis = (bus.in_n_bpsc == N_BPSC_BPSK) ? 4'd1 : {1'b0, bus.in_n_bpsc[3:1]};
        word_i = bus.in_bits[MAX_M-1:0];
        word_q = MAX_M'(bus.in_bits >> m_axis);
    end

    gray_level_decode #(.MAX_M(MAX_M), .LW(LW)) u_dec_i (
        .word  (word_i),
        .m     (m_axis),
        .level (lvl_i)
    );

    gray_level_decode #(.MAX_M(MAX_M), .LW(LW)) u_dec_q (
        .word  (word_q),
        .m     (m_axis),
        .level (lvl_q)
    );

    // Handshake and pipeline advance conditions.
    always_comb begin
        s2_adv       = !s2_valid || bus.out_ready;
        s1_adv       = !s1_valid || s2_adv;
        bus.in_ready = rstn && s1_adv;
        in_fire      = bus.in_valid && bus.in_ready;
        out_fire     = s2_valid && bus.out_ready;
    end

    // Scale select; illegal modes carry mode 0 so the product is zero.
    always_comb begin
        k_sel = 0;
        case (s1_mode)
            N_BPSC_BPSK:   k_sel = K1;
            N_BPSC_QPSK:   k_sel = K2;
            N_BPSC_QAM16:  k_sel = K4;
            N_BPSC_QAM64:  k_sel = K6;
            N_BPSC_QAM256: k_sel = K8;
            default:       k_sel = 0;
        endcase
        prod_i = int'(s1_lvl_i) * k_sel;
        prod_q = int'(s1_lvl_q) * k_sel;
    end

    // Stage 1: decoded levels, mode and last flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_lvl_i <= '0;
            s1_lvl_q <= '0;
            s1_mode  <= '0;
            s1_last  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_lvl_i <= lvl_i;
                s1_lvl_q <= (bus.in_n_bpsc == N_BPSC_BPSK) ? '0 : lvl_q;
                s1_mode  <= legal ? bus.in_n_bpsc : 4'd0;
                s1_last  <= bus.in_last;
            end
        end
    end

    // Stage 2: scaled point and last flag, held while stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_iq    <= '0;
            s2_last  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_iq   <= {IQ_WIDTH'(prod_i), IQ_WIDTH'(prod_q)};
                s2_last <= s1_last;
            end
        end
    end

    // Subcarrier index of the point in stage 2; a packet end restarts at 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sc_idx <= '0;
        end else if (out_fire) begin
            if (s2_last || sc_idx == 6'(N_SC - 1)) sc_idx <= '0;
            else sc_idx <= sc_idx + 6'd1;
        end
    end

    // Sticky flag for any accepted beat with an unsupported mode.
    always_ff @(posedge clk) begin
        if (!rstn) mode_err <= 1'b0;
        else if (in_fire && !legal) mode_err <= 1'b1;
    end

    // Output drive.
    always_comb begin
        bus.out_valid  = s2_valid;
        bus.out_iq     = s2_iq;
        bus.out_last   = s2_last;
        bus.out_sc_idx = sc_idx;
        bus.mode_err   = mode_err;
    end

endmodule

// File: tb/tb_qam_mapper_stream.sv
// Scoreboard bench for qam_mapper_stream: expected points are queued on
// input acceptance and compared on each output handshake.
module tb_qam_mapper_stream;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    qam_mapper_stream_if #(.IQ_WIDTH(16), .MAX_BPSC(8)) bus ();
    qam_mapper_stream_if #(.IQ_WIDTH(16), .MAX_BPSC(6)) bus6 ();

    qam_mapper_stream #(.IQ_WIDTH(16), .MAX_BPSC(8), .N_SC(48)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    qam_mapper_stream #(.IQ_WIDTH(16), .MAX_BPSC(6), .N_SC(48)) dut6 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus6)
    );

    typedef struct {
        logic [31:0] iq;
        logic        last;
        logic [5:0]  idx;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   next_idx = 0;
    bit   chk_lat = 0;
    bit   rand_ready = 0;
    bit   ready_fixed = 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gray_lvl(input int w, input int m);
        int g;
        g = 0;
        for (int j = 0; j < m; j++) g = g | (((w >> j) & 1) << (m - 1 - j));
        for (int b = 0; b < (1 << m); b++)
            if ((b ^ (b >> 1)) == g) return 2 * b - ((1 << m) - 1);
        return 0;
    endfunction

    function automatic logic [31:0] exp_iq(input logic [7:0] bits, input logic [3:0] n);
        int k;
        int m;
        int mask;
        int li;
        int lq;
        logic [15:0] i16;
        logic [15:0] q16;
        case (n)
            4'd1: return {(bits[0] ? 16'h4000 : 16'hC000), 16'h0000};
            4'd2: k = 11585;
            4'd4: k = 5181;
            4'd6: k = 2528;
            4'd8: k = 1257;
            default: return 32'h0;
        endcase
        m    = int'(n) / 2;
        mask = (1 << m) - 1;
        li   = gray_lvl(int'(bits) & mask, m);
        lq   = gray_lvl((int'(bits) >> m) & mask, m);
        i16  = 16'(li * k);
        q16  = 16'(lq * k);
        return {i16, q16};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        else bus.out_ready = ready_fixed;
    end

    logic [31:0] held_iq;
    logic        held_last;
    logic [5:0]  held_idx;
    bit          stalled = 0;
    exp_t        got_e;

    // Output monitor: sampled mid-cycle, after inputs and out_ready settle.
    always begin
        @(negedge clk);
        #4;
        if (!rstn) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
                check_eq("stall_iq", 64'(bus.out_iq), 64'(held_iq));
                check_eq("stall_last", 64'(bus.out_last), 64'(held_last));
                check_eq("stall_idx", 64'(bus.out_sc_idx), 64'(held_idx));
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    got_e = sb.pop_front();
                    check_eq("out_iq", 64'(bus.out_iq), 64'(got_e.iq));
                    check_eq("out_last", 64'(bus.out_last), 64'(got_e.last));
                    check_eq("out_sc_idx", 64'(bus.out_sc_idx), 64'(got_e.idx));
                    if (chk_lat) check_eq("latency", 64'(cyc - got_e.acc_cyc), 64'd2);
                end
            end
            stalled   = bus.out_valid && !bus.out_ready;
            held_iq   = bus.out_iq;
            held_last = bus.out_last;
            held_idx  = bus.out_sc_idx;
        end
    end

    task automatic send(input logic [7:0] bits, input logic [3:0] n, input logic last);
        exp_t e;
        bit   acc;
        int   guard;
        acc   = 0;
        guard = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_bits   = bits;
        bus.in_n_bpsc = n;
        bus.in_last   = last;
        while (!acc) begin
            #4;
            if (bus.in_ready) begin
                acc       = 1;
                e.iq      = exp_iq(bits, n);
                e.last    = last;
                e.idx     = 6'(next_idx);
                e.acc_cyc = cyc;
                sb.push_back(e);
                if (last || next_idx == 47) next_idx = 0;
                else next_idx++;
            end else begin
                guard++;
                if (guard > 300) begin
                    check_eq("in_ready_timeout", 64'(guard), 64'd0);
                    acc = 1;
                end
            end
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int g;
        logic [3:0] modes [5];
        modes[0] = 4'd1; modes[1] = 4'd2; modes[2] = 4'd4; modes[3] = 4'd6; modes[4] = 4'd8;

        rstn           = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_bits    = '0;
        bus.in_n_bpsc  = 4'd1;
        bus.in_last    = 1'b0;
        bus6.in_valid  = 1'b0;
        bus6.in_bits   = '0;
        bus6.in_n_bpsc = 4'd1;
        bus6.in_last   = 1'b0;
        bus6.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_iq", 64'(bus.out_iq), 64'd0);
        check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
        check_eq("rst_sc_idx", 64'(bus.out_sc_idx), 64'd0);
        check_eq("rst_mode_err", 64'(bus.mode_err), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // BPSK with latency check
        chk_lat = 1;
        send(8'h00, 4'd1, 1'b0);
        send(8'h01, 4'd1, 1'b0);
        idle();
        drain();
        chk_lat = 0;

        // 16-QAM sweep, 64-QAM and 256-QAM points
        for (int c = 0; c < 16; c++) send(8'(c), 4'd4, 1'b0);
        send(8'b0000_1001, 4'd6, 1'b0);
        send(8'b0011_0110, 4'd2, 1'b0);
        send(8'hFF, 4'd8, 1'b1);
        idle();
        drain();

        // 256-QAM is illegal on a 6-bit build
        check_eq("m6_err_before", 64'(bus6.mode_err), 64'd0);
        @(negedge clk);
        bus6.in_valid  = 1'b1;
        bus6.in_bits   = 6'h3F;
        bus6.in_n_bpsc = 4'd8;
        #4;
        check_eq("m6_in_ready", 64'(bus6.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus6.in_valid = 1'b0;
        g = 0;
        while (!bus6.out_valid && g < 10) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_eq("m6_out_valid", 64'(bus6.out_valid), 64'd1);
        check_eq("m6_out_iq", 64'(bus6.out_iq), 64'd0);
        check_eq("m6_mode_err", 64'(bus6.mode_err), 64'd1);

        // Index wrap and packet restart
        for (int b = 0; b < 60; b++) send(8'($urandom_range(0, 255)), 4'd4, 1'(b == 52));
        idle();
        drain();

        // Random modes under random backpressure
        rand_ready = 1;
        for (int b = 0; b < 100; b++)
            send(8'($urandom_range(0, 255)), modes[$urandom_range(0, 4)],
                 1'($urandom_range(0, 9) == 0));
        idle();
        drain();
        rand_ready = 0;

        // Reset with two points in flight
        ready_fixed = 0;
        repeat (2) @(posedge clk);
        send(8'h12, 4'd4, 1'b0);
        send(8'h34, 4'd4, 1'b0);
        idle();
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        sb.delete();
        next_idx    = 0;
        ready_fixed = 1;
        @(negedge clk);
        rstn = 1'b1;
        send(8'h5A, 4'd6, 1'b0);
        send(8'hC3, 4'd8, 1'b0);
        send(8'h02, 4'd2, 1'b1);
        idle();
        drain();
        check_eq("mode_err_clear", 64'(bus.mode_err), 64'd0);

        // Illegal modes still produce a zero point
        send(8'hA5, 4'd3, 1'b0);
        send(8'h5A, 4'd0, 1'b0);
        send(8'h0F, 4'd9, 1'b0);
        send(8'h0F, 4'd4, 1'b1);
        idle();
        drain();
        check_eq("mode_err_sticky", 64'(bus.mode_err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
